// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
// Holds the FSM state encoding, datapath widths and the byte-merge helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = 4;
  localparam int LAT_CNT_W   = 4;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DMEM_DATA_W-1:0] be_merge(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] new_word,
    input logic [DMEM_BE_W-1:0]   be
  );
    logic [DMEM_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DMEM_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Byte-enabled 32-bit word array: synchronous write, combinational read.
// One write port and one read port, both word-indexed.
module dmem_word_array
  import dmem_responder_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DMEM_BE_W-1:0]   wr_be,
  input  logic [DMEM_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DMEM_DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; only the control that gates writes is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= be_merge(mem[wr_idx], wr_data, wr_be);
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, completes it LATENCY
// cycles after acceptance and flags any change to a request while it is in flight.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dmem_use,
  input  logic                   dmem_we,
  input  logic [ADDR_W-1:0]      dmem_addr,
  input  logic [DMEM_BE_W-1:0]   dmem_be,
  input  logic [DMEM_DATA_W-1:0] dmem_wdata,
  output logic                   dmem_ready,
  output logic [DMEM_DATA_W-1:0] dmem_rdata,
  output logic                   proto_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  if (LATENCY < 1 || LATENCY > (2 ** LAT_CNT_W) - 1) begin : g_latency_range
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   count_q, count_d;
  logic                   we_q, we_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DMEM_BE_W-1:0]   be_q, be_d;
  logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [DMEM_DATA_W-1:0] rdata_q, rdata_d;
  logic                   perr_q, perr_d;

  logic                   req_changed;
  logic [IDX_W-1:0]       rd_idx;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  logic                   arr_wr_en;
  logic [1:0]             unused_addr_lsb;

  assign unused_addr_lsb = dmem_addr[1:0];

  assign req_changed = ~dmem_use
                     | (dmem_we != we_q)
                     | (dmem_addr[ADDR_W-1:2] != idx_q)
                     | (dmem_be != be_q)
                     | (dmem_wdata != wdata_q);

  // With LATENCY=1 the load data is sampled on the accepting edge, before capture.
  assign rd_idx    = (state_q == ST_IDLE) ? dmem_addr[ADDR_W-1:2] : idx_q;
  assign arr_wr_en = (state_q == ST_DONE) & we_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = we_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dmem_use) begin
          we_d    = dmem_we;
          idx_d   = dmem_addr[ADDR_W-1:2];
          be_d    = dmem_be;
          wdata_d = dmem_wdata;
          count_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = ST_DONE;
            if (!dmem_we) rdata_d = arr_rdata;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = arr_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && req_changed) perr_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  dmem_word_array #(.IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .wr_en   (arr_wr_en),
    .wr_idx  (idx_q),
    .wr_be   (be_q),
    .wr_data (wdata_q),
    .rd_idx  (rd_idx),
    .rd_data (arr_rdata)
  );

  // A request held during reset is not accepted, so the port reads idle.
  assign dmem_ready = ((state_q == ST_IDLE) & (~dmem_use | ~rst)) | (state_q == ST_DONE);
  assign dmem_rdata = rdata_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 3, 1, 15) driven
// by directed and random load/store traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int ADDR_W = 12;
  localparam int NI     = 3;
  localparam int NW     = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NI-1:0]             use_s, we_s, ready_s, perr_s;
  logic [NI-1:0][ADDR_W-1:0] addr_s;
  logic [NI-1:0][3:0]        be_s;
  logic [NI-1:0][31:0]       wdata_s, rdata_s;

  logic [31:0] mem_m [NI][NW];
  logic [31:0] last_rd [NI];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .dmem_use(use_s[0]), .dmem_we(we_s[0]), .dmem_addr(addr_s[0]),
    .dmem_be(be_s[0]), .dmem_wdata(wdata_s[0]), .dmem_ready(ready_s[0]),
    .dmem_rdata(rdata_s[0]), .proto_err(perr_s[0]));

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .dmem_use(use_s[1]), .dmem_we(we_s[1]), .dmem_addr(addr_s[1]),
    .dmem_be(be_s[1]), .dmem_wdata(wdata_s[1]), .dmem_ready(ready_s[1]),
    .dmem_rdata(rdata_s[1]), .proto_err(perr_s[1]));

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .dmem_use(use_s[2]), .dmem_we(we_s[2]), .dmem_addr(addr_s[2]),
    .dmem_be(be_s[2]), .dmem_wdata(wdata_s[2]), .dmem_ready(ready_s[2]),
    .dmem_rdata(rdata_s[2]), .proto_err(perr_s[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic use_v, input logic we,
                       input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    use_s[k]   = use_v;
    we_s[k]    = we;
    addr_s[k]  = addr;
    be_s[k]    = be;
    wdata_s[k] = wd;
  endtask

  // One complete transaction, leaving the request held through the DONE cycle.
  task automatic do_req(input int k, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int lat = lat_of(k);
    int w = int'(addr[5:2]);
    logic [31:0] mask;
    drive(k, 1'b1, we, addr, be, wd);
    @(negedge clk);
    check($sformatf("L%0d accept_ready", lat), 32'(ready_s[k]), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check($sformatf("L%0d ready_cyc%0d", lat, c), 32'(ready_s[k]), 32'(c == lat));
    end
    if (we) begin
      check($sformatf("L%0d rdata_hold_on_store", lat), rdata_s[k], last_rd[k]);
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      mem_m[k][w] = (mem_m[k][w] & ~mask) | (wd & mask);
    end else begin
      check($sformatf("L%0d load_w%0d", lat, w), rdata_s[k], mem_m[k][w]);
      last_rd[k] = mem_m[k][w];
    end
    check($sformatf("L%0d proto_err_clear", lat), 32'(perr_s[k]), 32'd0);
  endtask

  task automatic idle(input int k, input int n);
    drive(k, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("L%0d idle_ready", lat_of(k)), 32'(ready_s[k]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b0;
    use_s = '1;
    we_s = '0;
    addr_s = '0;
    be_s = '0;
    wdata_s = '0;
    for (int k = 0; k < NI; k++) last_rd[k] = '0;

    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_ready%0d", k), 32'(ready_s[k]), 32'd1);
      check($sformatf("rst_perr%0d", k), 32'(perr_s[k]), 32'd0);
      check($sformatf("rst_rdata%0d", k), rdata_s[k], 32'd0);
    end
    @(posedge clk); #1; use_s = '0;
    @(posedge clk); #1; rst = 1'b1;

    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < NW; w++)
        do_req(k, 1'b1, ADDR_W'(w * 4 + int'($urandom_range(0, 3))), 4'hF, $urandom);
      do_req(k, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      do_req(k, 1'b0, 12'h010, 4'h0, 32'h0);
      check($sformatf("L%0d deadbeef", lat_of(k)), rdata_s[k], 32'hDEADBEEF);
      do_req(k, 1'b1, 12'h010, 4'b0010, 32'h0000AA00);
      do_req(k, 1'b0, 12'h012, 4'h0, 32'h0);
      check($sformatf("L%0d partial", lat_of(k)), rdata_s[k], 32'hDEADAAEF);
      idle(k, 2);
      for (int i = 0; i < 24; i++)
        do_req(k, 1'($urandom_range(0, 1)),
               ADDR_W'(int'($urandom_range(0, NW - 1)) * 4 + int'($urandom_range(0, 3))),
               4'($urandom_range(0, 15)), $urandom);
      idle(k, 3);
    end

    // Address changed mid-flight: sticky error, completion uses the original word.
    do_req(0, 1'b1, 12'h014, 4'hF, 32'h12345678);
    do_req(0, 1'b1, 12'h024, 4'hF, 32'h87654321);
    idle(0, 1);
    drive(0, 1'b1, 1'b0, 12'h014, 4'h0, 32'h0);
    @(negedge clk);
    check("perr accept_ready", 32'(ready_s[0]), 32'd0);
    drive(0, 1'b1, 1'b0, 12'h024, 4'h0, 32'h0);
    @(negedge clk);
    check("perr busy1_ready", 32'(ready_s[0]), 32'd0);
    @(negedge clk);
    check("perr busy2_ready", 32'(ready_s[0]), 32'd0);
    check("perr set", 32'(perr_s[0]), 32'd1);
    @(negedge clk);
    check("perr done_ready", 32'(ready_s[0]), 32'd1);
    check("perr orig_addr", rdata_s[0], 32'h12345678);
    last_rd[0] = 32'h12345678;
    idle(0, 3);
    check("perr sticky", 32'(perr_s[0]), 32'd1);

    // Reset during a store's BUSY phase: the target word must keep its old value.
    drive(0, 1'b1, 1'b1, 12'h014, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("rstmid accept_ready", 32'(ready_s[0]), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstmid ready", 32'(ready_s[0]), 32'd1);
    check("rstmid perr", 32'(perr_s[0]), 32'd0);
    check("rstmid rdata", rdata_s[0], 32'd0);
    for (int k = 0; k < NI; k++) last_rd[k] = '0;
    @(posedge clk); #1; use_s[0] = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    idle(0, 2);
    do_req(0, 1'b0, 12'h014, 4'h0, 32'h0);
    check("rstmid word_kept", rdata_s[0], 32'h12345678);
    idle(0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
